// File: rtl/opl_timer_ctrl.sv
// opl_timer_ctrl: register-side control for the two OPL2 interval timers.
//
// Decodes host writes to the timer preset/control registers, drives the
// init/start inputs of the Timer 1 and Timer 2 instances, collects their
// overflow pulses into sticky, maskable flags, and forms the status byte
// and the active-low IRQ line.
//
// Optional feature (macro OPL_TIMER_CSM_EN): adds register 0x08 (csm_en in
// din[7]) and output csm_key_on, a one-cycle pulse following any Timer 1
// overflow while csm_en is set, independent of the Timer 1 mask.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   wr/addr/din  single-cycle host register write
//   t1_init      Timer 1 preset value
//   t2_init      Timer 2 preset value
//   t1_start     Timer 1 run enable
//   t2_start     Timer 2 run enable
//   t1_overflow  one-cycle overflow pulse from Timer 1
//   t2_overflow  one-cycle overflow pulse from Timer 2
//   status       {irq, t1_flag, t2_flag, STATUS_LOW}
//   irq_n        active-low interrupt request
//   csm_key_on   composite-sine key-on pulse (OPL_TIMER_CSM_EN only)
module opl_timer_ctrl #(
  parameter logic [7:0] ADDR_T1    = 8'h02,
  parameter logic [7:0] ADDR_T2    = 8'h03,
  parameter logic [7:0] ADDR_CTRL  = 8'h04,
  parameter logic [4:0] STATUS_LOW = 5'b00110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] t1_init,
  output logic [7:0] t2_init,
  output logic       t1_start,
  output logic       t2_start,
  input  logic       t1_overflow,
  input  logic       t2_overflow,
  output logic [7:0] status,
`ifdef OPL_TIMER_CSM_EN
  output logic       csm_key_on,
`endif
  output logic       irq_n
);

`ifdef OPL_TIMER_CSM_EN
  localparam logic [7:0] ADDR_CSM = 8'h08;
`endif

  logic mask_t1;
  logic mask_t2;
  logic t1_flag;
  logic t2_flag;
  logic irq;

  // Write decode
  logic wr_t1;
  logic wr_t2;
  logic wr_irq_rst;
  logic wr_ctrl;

  always_comb begin
    wr_t1      = wr && (addr == ADDR_T1);
    wr_t2      = wr && (addr == ADDR_T2);
    wr_irq_rst = wr && (addr == ADDR_CTRL) && din[7];
    wr_ctrl    = wr && (addr == ADDR_CTRL) && !din[7];
  end

  // Preset, mask and start registers
  always_ff @(posedge clk) begin
    if (reset) begin
      t1_init  <= 8'h00;
      t2_init  <= 8'h00;
      mask_t1  <= 1'b0;
      mask_t2  <= 1'b0;
      t1_start <= 1'b0;
      t2_start <= 1'b0;
    end else begin
      if (wr_t1) t1_init <= din;
      if (wr_t2) t2_init <= din;
      if (wr_ctrl) begin
        mask_t1  <= din[6];
        mask_t2  <= din[5];
        t2_start <= din[1];
        t1_start <= din[0];
      end
    end
  end

  // Sticky flags: an unmasked overflow beats a same-cycle IRQ reset, and
  // the mask consulted is the one in place before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      t1_flag <= 1'b0;
      t2_flag <= 1'b0;
    end else begin
      t1_flag <= (t1_overflow && !mask_t1) || (t1_flag && !wr_irq_rst);
      t2_flag <= (t2_overflow && !mask_t2) || (t2_flag && !wr_irq_rst);
    end
  end

`ifdef OPL_TIMER_CSM_EN
  logic csm_en;

  // CSM enable register and key-on pulse generator
  always_ff @(posedge clk) begin
    if (reset) begin
      csm_en     <= 1'b0;
      csm_key_on <= 1'b0;
    end else begin
      if (wr && (addr == ADDR_CSM)) csm_en <= din[7];
      csm_key_on <= t1_overflow && csm_en;
    end
  end
`endif

  // Status and IRQ derived directly from the flag registers
  always_comb begin
    irq    = t1_flag | t2_flag;
    irq_n  = ~irq;
    status = {irq, t1_flag, t2_flag, STATUS_LOW};
  end

endmodule

// File: tb/tb_opl_timer_ctrl.sv
module tb_opl_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic [7:0] t1_init;
  logic [7:0] t2_init;
  logic       t1_start;
  logic       t2_start;
  logic       t1_overflow = 1'b0;
  logic       t2_overflow = 1'b0;
  logic [7:0] status;
  logic       irq_n;
`ifdef OPL_TIMER_CSM_EN
  logic       csm_key_on;
`endif

  int checks = 0;
  int failures = 0;

  opl_timer_ctrl dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .addr(addr),
    .din(din),
    .t1_init(t1_init),
    .t2_init(t2_init),
    .t1_start(t1_start),
    .t2_start(t2_start),
    .t1_overflow(t1_overflow),
    .t2_overflow(t2_overflow),
    .status(status),
`ifdef OPL_TIMER_CSM_EN
    .csm_key_on(csm_key_on),
`endif
    .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  // Reference state, described in register-map terms
  logic [7:0] m_t1_init, m_t2_init;
  logic       m_t1_start, m_t2_start, m_mask1, m_mask2, m_flag1, m_flag2;
  logic       m_csm_en, m_csm_pulse;

  function automatic logic [7:0] m_status();
    logic irq;
    irq = m_flag1 | m_flag2;
    return {irq, m_flag1, m_flag2, 5'b00110};
  endfunction

  // Apply one clock of stimulus to both DUT and reference.
  task automatic step(input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic o1, input logic o2);
    logic n_flag1, n_flag2, irq_clear;
    reset = r; wr = w; addr = a; din = d; t1_overflow = o1; t2_overflow = o2;
    @(posedge clk);
    if (r) begin
      m_t1_init = 8'h00; m_t2_init = 8'h00;
      m_t1_start = 0; m_t2_start = 0; m_mask1 = 0; m_mask2 = 0;
      m_flag1 = 0; m_flag2 = 0; m_csm_en = 0; m_csm_pulse = 0;
    end else begin
      irq_clear = w && a == 8'h04 && d[7];
      n_flag1 = (o1 && !m_mask1) ? 1'b1 : (irq_clear ? 1'b0 : m_flag1);
      n_flag2 = (o2 && !m_mask2) ? 1'b1 : (irq_clear ? 1'b0 : m_flag2);
      m_csm_pulse = o1 && m_csm_en;
      if (w) begin
        case (a)
          8'h02: m_t1_init = d;
          8'h03: m_t2_init = d;
          8'h04: if (!d[7]) begin
                   m_mask1 = d[6]; m_mask2 = d[5];
                   m_t2_start = d[1]; m_t1_start = d[0];
                 end
          8'h08: m_csm_en = d[7];
          default: ;
        endcase
      end
      m_flag1 = n_flag1; m_flag2 = n_flag2;
    end
    #1;
    reset = 0; wr = 0; addr = 8'h00; din = 8'h00; t1_overflow = 0; t2_overflow = 0;
  endtask

  task automatic test_reset();
    step(1, 1, 8'h02, 8'h55, 1, 1);
    checks++; if (t1_init !== 8'h00) begin failures++; $display("FAIL reset_t1_init got=%h exp=00", t1_init); end
    checks++; if (t2_init !== 8'h00) begin failures++; $display("FAIL reset_t2_init got=%h exp=00", t2_init); end
    checks++; if ({t1_start, t2_start} !== 2'b00) begin failures++; $display("FAIL reset_start got=%b exp=00", {t1_start, t2_start}); end
    checks++; if (status !== 8'h06) begin failures++; $display("FAIL reset_status got=%h exp=06", status); end
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL reset_irq_n got=%b exp=1", irq_n); end
  endtask

  task automatic test_writes();
    step(0, 1, 8'h02, 8'hF0, 0, 0);
    step(0, 1, 8'h03, 8'h10, 0, 0);
    step(0, 1, 8'h04, 8'h03, 0, 0);
    checks++; if (t1_init !== 8'hF0) begin failures++; $display("FAIL wr_t1_init got=%h exp=f0", t1_init); end
    checks++; if (t2_init !== 8'h10) begin failures++; $display("FAIL wr_t2_init got=%h exp=10", t2_init); end
    checks++; if ({t1_start, t2_start} !== 2'b11) begin failures++; $display("FAIL wr_start got=%b exp=11", {t1_start, t2_start}); end
    checks++; if (status !== 8'h06) begin failures++; $display("FAIL wr_status_idle got=%h exp=06", status); end
    step(0, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (status !== 8'hC6) begin failures++; $display("FAIL t1_ovf_status got=%h exp=c6", status); end
    checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL t1_ovf_irq_n got=%b exp=0", irq_n); end
  endtask

  task automatic test_mask();
    step(0, 1, 8'h04, 8'h80, 0, 0);
    step(0, 1, 8'h04, 8'h41, 0, 0);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (status !== 8'h06) begin failures++; $display("FAIL masked_t1_status got=%h exp=06", status); end
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL masked_t1_irq_n got=%b exp=1", irq_n); end
    step(0, 0, 8'h00, 8'h00, 0, 1);
    checks++; if (status !== 8'hA6) begin failures++; $display("FAIL t2_ovf_status got=%h exp=a6", status); end
  endtask

  task automatic test_irq_reset();
    step(0, 1, 8'h04, 8'h03, 0, 0);
    step(0, 0, 8'h00, 8'h00, 1, 1);
    checks++; if (status !== 8'hE6) begin failures++; $display("FAIL both_flags got=%h exp=e6", status); end
    step(0, 1, 8'h04, 8'h80, 0, 0);
    checks++; if (status !== 8'h06) begin failures++; $display("FAIL irq_rst_status got=%h exp=06", status); end
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL irq_rst_irq_n got=%b exp=1", irq_n); end
    checks++; if ({t1_start, t2_start} !== 2'b11) begin failures++; $display("FAIL irq_rst_start got=%b exp=11", {t1_start, t2_start}); end
    step(0, 0, 8'h00, 8'h00, 1, 1);
    step(0, 1, 8'h04, 8'h80, 1, 0);
    checks++; if (status !== 8'hC6) begin failures++; $display("FAIL irq_rst_vs_ovf got=%h exp=c6", status); end
  endtask

  task automatic test_mask_boundary();
    step(0, 1, 8'h04, 8'h80, 0, 0);
    step(0, 1, 8'h04, 8'h23, 0, 0);
    step(0, 1, 8'h04, 8'h00, 0, 1);
    checks++; if (status !== 8'h06) begin failures++; $display("FAIL old_mask_decides got=%h exp=06", status); end
    step(0, 1, 8'h05, 8'hFF, 0, 0);
    checks++; if ({t1_init, t2_init} !== 16'hF010) begin failures++; $display("FAIL ignored_addr_init got=%h exp=f010", {t1_init, t2_init}); end
    checks++; if ({t1_start, t2_start, status, irq_n} !== {2'b00, 8'h06, 1'b1}) begin
      failures++; $display("FAIL ignored_addr_ctrl got=%b exp=%b", {t1_start, t2_start, status, irq_n}, {2'b00, 8'h06, 1'b1});
    end
    // Overflow while stopped and unmasked still sets the flag
    step(0, 0, 8'h00, 8'h00, 0, 1);
    checks++; if (status !== 8'hA6) begin failures++; $display("FAIL stopped_ovf got=%h exp=a6", status); end
  endtask

`ifdef OPL_TIMER_CSM_EN
  task automatic test_csm();
    step(0, 1, 8'h04, 8'h40, 0, 0);
    step(0, 1, 8'h08, 8'h80, 0, 0);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (csm_key_on !== 1'b1) begin failures++; $display("FAIL csm_pulse got=%b exp=1", csm_key_on); end
    step(0, 0, 8'h00, 8'h00, 0, 0);
    checks++; if (csm_key_on !== 1'b0) begin failures++; $display("FAIL csm_pulse_width got=%b exp=0", csm_key_on); end
    step(0, 1, 8'h08, 8'h00, 0, 0);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    checks++; if (csm_key_on !== 1'b0) begin failures++; $display("FAIL csm_disabled got=%b exp=0", csm_key_on); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] addrs [6];
    logic [7:0] a;
    addrs[0] = 8'h02; addrs[1] = 8'h03; addrs[2] = 8'h04;
    addrs[3] = 8'h05; addrs[4] = 8'h08; addrs[5] = 8'h00;
    step(1, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 400; i++) begin
      a = addrs[$urandom_range(5)];
      if (a == 8'h00) a = 8'($urandom);
      step(($urandom_range(63) == 0), ($urandom_range(1) == 1), a, 8'($urandom),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0));
      checks++;
      if ({t1_init, t2_init, t1_start, t2_start} !== {m_t1_init, m_t2_init, m_t1_start, m_t2_start}) begin
        failures++;
        $display("FAIL rand_regs cyc=%0d got=%h exp=%h", i, {t1_init, t2_init, t1_start, t2_start},
                 {m_t1_init, m_t2_init, m_t1_start, m_t2_start});
      end
      checks++;
      if ({status, irq_n} !== {m_status(), ~(m_flag1 | m_flag2)}) begin
        failures++;
        $display("FAIL rand_status cyc=%0d got=%h exp=%h", i, {status, irq_n}, {m_status(), ~(m_flag1 | m_flag2)});
      end
`ifdef OPL_TIMER_CSM_EN
      checks++;
      if (csm_key_on !== m_csm_pulse) begin
        failures++;
        $display("FAIL rand_csm cyc=%0d got=%b exp=%b", i, csm_key_on, m_csm_pulse);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_mask();
    test_irq_reset();
    test_mask_boundary();
`ifdef OPL_TIMER_CSM_EN
    test_csm();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
